// File: rtl/game_time_counter.sv
// Elapsed game time counter: counts one BCD second (mm:ss) per rising edge
// of time_tik, with run/pause/hold tracking and an expiry flag at LIMIT_MIN:00.
//
// Ports:
//   clock_25    in  25 MHz system clock
//   reset       in  asynchronous active-low reset
//   sync_reset  in  synchronous clear, highest priority
//   start       in  game running enable
//   game_over   in  freeze request, latched into HOLD
//   time_tik    in  registered divisor MSB
//   sec_units   out BCD seconds units (0-9)
//   sec_tens    out BCD seconds tens (0-5)
//   min_units   out BCD minutes units (0-9)
//   min_tens    out BCD minutes tens (0-9)
//   sec_pulse   out one-cycle pulse when new digits appear
//   running     out high in RUN
//   time_up     out high in EXPIRED
module game_time_counter #(
    parameter int LIMIT_MIN = 99
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       sync_reset,
    input  logic       start,
    input  logic       game_over,
    input  logic       time_tik,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       sec_pulse,
    output logic       running,
    output logic       time_up
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [1:0] EXPIRED = 2'd3;

    localparam logic [3:0] LIM_TENS  = 4'(LIMIT_MIN / 10);
    localparam logic [3:0] LIM_UNITS = 4'(LIMIT_MIN % 10);

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       tik_d;
    logic       tick;

    logic [3:0] inc_su, inc_st, inc_mu, inc_mt;
    logic [3:0] su_nx, st_nx, mu_nx, mt_nx;
    logic       pulse_nx;
    logic       at_limit;

    assign tick = time_tik & ~tik_d;

    // BCD ripple increment, digit by digit
    always_comb begin
        inc_su = sec_units;
        inc_st = sec_tens;
        inc_mu = min_units;
        inc_mt = min_tens;
        if (sec_units == 4'd9) begin
            inc_su = 4'd0;
            if (sec_tens == 4'd5) begin
                inc_st = 4'd0;
                if (min_units == 4'd9) begin
                    inc_mu = 4'd0;
                    inc_mt = (min_tens == 4'd9) ? 4'd0 : min_tens + 4'd1;
                end else begin
                    inc_mu = min_units + 4'd1;
                end
            end else begin
                inc_st = sec_tens + 4'd1;
            end
        end else begin
            inc_su = sec_units + 4'd1;
        end
    end

    assign at_limit = (inc_mt == LIM_TENS) && (inc_mu == LIM_UNITS) &&
                      (inc_st == 4'd0) && (inc_su == 4'd0);

    always_comb begin
        state_nx = state;
        su_nx    = sec_units;
        st_nx    = sec_tens;
        mu_nx    = min_units;
        mt_nx    = min_tens;
        pulse_nx = 1'b0;
        case (state)
            IDLE: begin
                if (game_over)
                    state_nx = HOLD;
                else if (start)
                    state_nx = RUN;
            end
            RUN: begin
                if (game_over) begin
                    state_nx = HOLD;
                end else if (!start) begin
                    state_nx = IDLE;
                end else if (tick) begin
                    su_nx    = inc_su;
                    st_nx    = inc_st;
                    mu_nx    = inc_mu;
                    mt_nx    = inc_mt;
                    pulse_nx = 1'b1;
                    if (at_limit)
                        state_nx = EXPIRED;
                end
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tik_d     <= 1'b0;
            sec_units <= 4'd0;
            sec_tens  <= 4'd0;
            min_units <= 4'd0;
            min_tens  <= 4'd0;
            sec_pulse <= 1'b0;
            running   <= 1'b0;
            time_up   <= 1'b0;
        end else if (sync_reset) begin
            state     <= IDLE;
            tik_d     <= 1'b0;
            sec_units <= 4'd0;
            sec_tens  <= 4'd0;
            min_units <= 4'd0;
            min_tens  <= 4'd0;
            sec_pulse <= 1'b0;
            running   <= 1'b0;
            time_up   <= 1'b0;
        end else begin
            state     <= state_nx;
            tik_d     <= time_tik;
            sec_units <= su_nx;
            sec_tens  <= st_nx;
            min_units <= mu_nx;
            min_tens  <= mt_nx;
            sec_pulse <= pulse_nx;
            // flags follow the next state so they change on the same edge
            running   <= (state_nx == RUN);
            time_up   <= (state_nx == EXPIRED);
        end
    end

endmodule

// File: doc/game_time_counter.md
# game_time_counter

Elapsed-game-time counter that sits directly downstream of the time-tick divisor in the time_and_score path. It edge-detects the divisor's `time_tik` square wave and counts one game second per rising edge. The count is kept in BCD as mm:ss (00:00–99:59) for the seven-segment/VGA score display. It also tracks run/pause/hold state and flags when a configurable minute limit is reached.

## Interface
- `LIMIT_MIN`, default 99: minute limit, legal range 1..99. Reaching LIMIT_MIN:00 ends timing.
- `clock_25` in 1: 25 MHz system clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `sync_reset` in 1: synchronous clear, same net that drives the divisor. Highest synchronous priority.
- `start` in 1: game-running enable, same net that drives the divisor.
- `game_over` in 1: level from game logic. Freezes the count until `sync_reset`.
- `time_tik` in 1: divisor MSB. Already registered on `clock_25`, so no synchroniser is needed.
- `sec_units` out 4: BCD 0–9.
- `sec_tens` out 4: BCD 0–5, upper bit always 0.
- `min_units` out 4: BCD 0–9.
- `min_tens` out 4: BCD 0–9.
- `sec_pulse` out 1: one-cycle pulse, high in the cycle the new digits first appear.
- `running` out 1: high only in state RUN.
- `time_up` out 1: high only in state EXPIRED.

## Operation
- Edge detector:
  - Register `tik_d` samples `time_tik` every cycle.
  - `tick = time_tik & ~tik_d` (combinational).
- States: IDLE, RUN, HOLD, EXPIRED. All outputs are registered.
- Async reset (`reset`=0):
  - state goes to IDLE.
  - all digits, `tik_d`, `sec_pulse`, `running` and `time_up` go to 0.
- `sync_reset`=1:
  - same result as async reset, applied on the clock edge.
  - overrides every other input in that cycle, including a coincident `tick`.
- Transitions, evaluated when `sync_reset`=0:
  - IDLE, `start`=1 and `game_over`=0 → RUN.
  - IDLE, `game_over`=1 → HOLD.
  - RUN, `game_over`=1 → HOLD. Takes priority over `start` and `tick`.
  - RUN, `start`=0 → IDLE. Digits are retained, so a later `start` resumes from the held count.
  - RUN, `tick`, `start`=1 and `game_over`=0 → increment.
    - If the result equals LIMIT_MIN:00, go to EXPIRED on the same edge.
  - HOLD and EXPIRED: no exit except `sync_reset` or `reset`. Digits are frozen.
- Increment (BCD ripple):
  - `sec_units` 9→0 carries into `sec_tens`.
  - `sec_tens` 5→0 carries into `min_units`.
  - `min_units` 9→0 carries into `min_tens`.
  - No binary intermediate. Digits never leave their legal range.
- A `tick` in IDLE, HOLD or EXPIRED is discarded; it is never queued.
- A count of 99:59 with LIMIT_MIN=99 cannot occur, because EXPIRED is entered at 99:00.

## Timing
- Increment latency:
  - `time_tik` rises and is visible after edge N.
  - `tick` is high during cycle N→N+1.
  - Digits update at edge N+1, and `sec_pulse`=1 for exactly cycle N+1→N+2.
- At most one increment per `time_tik` rising edge. A `time_tik` that stays high never re-counts.
- `time_tik` period is 2^25 cycles (~1.34 s). The block makes no assumption about the period; any rising edge spaced 2 or more cycles apart is counted.
- The divisor holds `time_tik`=0 while `start`=0. The first count after `start` rises therefore arrives 2^24 cycles later.
- State change and digit update happen on the same edge.
  - `running` drops on the edge that enters HOLD, IDLE or EXPIRED.
  - `time_up` rises on the edge whose increment reaches the limit. `sec_pulse` is also high in that cycle.
- `reset` asserted mid-count clears all outputs immediately, with no clock needed. Operation resumes from IDLE 00:00 after deassertion.

## Test plan
- Count and carry:
  - Stimulus: reset, `start`=1, then 61 `time_tik` pulses (4 high / 4 low cycles).
  - Required: digits 01:01, `sec_pulse` count = 61, each pulse exactly 1 cycle and 1 cycle after the `time_tik` rise.
- Held level:
  - Stimulus: `time_tik` held high for 100 cycles in RUN.
  - Required: exactly one increment.
- Pause and resume:
  - Stimulus: count to 00:07, drop `start`, apply 3 pulses, raise `start`, apply 2 pulses.
  - Required: 00:07 held while paused, `running`=0; final value 00:09.
- Game over priority:
  - Stimulus: at 00:12, assert `game_over` in the same cycle as `tick`.
  - Required: HOLD at 00:12; further pulses ignored; `sync_reset` returns the block to IDLE 00:00.
- Limit:
  - Stimulus: LIMIT_MIN=2, 120 pulses.
  - Required: 02:00 with `time_up`=1 and `running`=0 on the 120th update; pulse 121 is ignored.
- Reset priority:
  - Stimulus: `sync_reset` coincident with `tick` at 00:33.
  - Required: 00:00, IDLE, `sec_pulse`=0.
  - Stimulus: async `reset` pulse mid-cycle.
  - Required: outputs are 0 before the next clock edge.
